// File: rtl/ex_mem_stage.sv
// ex_mem_stage: elastic EX->MEM pipeline register with valid/ready handshake,
// synchronous flush and gated write enables.
// Optional build macro: EXM_SKID_EN adds a skid register so that ready_E is
// registered and carries no combinational path from ready_M.
module ex_mem_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              valid_E,
  output logic              ready_E,
  input  logic              RegW_enable_E,
  input  logic              Mem_Write_E,
  input  logic              Result_src_E,
  input  logic [XLEN-1:0]   ALU_result_E,
  input  logic [XLEN-1:0]   Write_Data_E,
  input  logic [REG_AW-1:0] RDadd_E,
  output logic              valid_M,
  input  logic              ready_M,
  output logic              RegW_enable_M,
  output logic              Mem_Write_M,
  output logic              Result_src_M,
  output logic [XLEN-1:0]   ALU_result_M,
  output logic [XLEN-1:0]   Write_Data_M,
  output logic [REG_AW-1:0] RDadd_M
);

  typedef struct packed {
    logic              regw;
    logic              memw;
    logic              res_src;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   wdata;
    logic [REG_AW-1:0] rd;
  } bundle_t;

  bundle_t w_in;
  logic    w_ready;
  logic    w_in_xfer;
  logic    w_out_xfer;

  bundle_t r_main;
  logic    r_main_valid;

  assign w_in = '{regw:    RegW_enable_E,
                  memw:    Mem_Write_E,
                  res_src: Result_src_E,
                  alu:     ALU_result_E,
                  wdata:   Write_Data_E,
                  rd:      RDadd_E};

  assign w_in_xfer  = valid_E && w_ready;
  assign w_out_xfer = r_main_valid && ready_M;

`ifdef EXM_SKID_EN
  bundle_t r_skid;
  logic    r_skid_valid;

  // Ready depends only on skid occupancy, so it is a pure register output.
  assign w_ready = !r_skid_valid;

  // Main/skid occupancy and payload update; skid refills main on a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main       <= '0;
      r_main_valid <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      // Kill held entries and the incoming bundle; payloads keep their value.
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_xfer) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_skid_valid <= 1'b0;
      end else if (w_in_xfer) begin
        r_main <= w_in;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (!r_main_valid) begin
      if (w_in_xfer) begin
        r_main       <= w_in;
        r_main_valid <= 1'b1;
      end
    end else if (w_in_xfer) begin
      // Main is full and stalled: park the new bundle in the skid slot.
      r_skid       <= w_in;
      r_skid_valid <= 1'b1;
    end
  end
`else
  // Single entry: accept when empty or when the held bundle leaves this cycle.
  assign w_ready = !r_main_valid || ready_M;

  // Main register occupancy and payload update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main       <= '0;
      r_main_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
    end else if (w_in_xfer) begin
      r_main       <= w_in;
      r_main_valid <= 1'b1;
    end else if (w_out_xfer) begin
      r_main_valid <= 1'b0;
    end
  end
`endif

  assign ready_E       = w_ready;
  assign valid_M       = r_main_valid;
  // A bubble must never write the register file or memory.
  assign RegW_enable_M = r_main.regw & r_main_valid;
  assign Mem_Write_M   = r_main.memw & r_main_valid;
  assign Result_src_M  = r_main.res_src;
  assign ALU_result_M  = r_main.alu;
  assign Write_Data_M  = r_main.wdata;
  assign RDadd_M       = r_main.rd;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed test-plan phases plus a
// randomized phase, checked by a queue-based reference model.
module tb_ex_mem_stage;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
`ifdef EXM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic              regw;
    logic              memw;
    logic              rsrc;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   wd;
    logic [REG_AW-1:0] rd;
  } bun_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              valid_E = 1'b0;
  logic              ready_E;
  logic              RegW_enable_E = 1'b0;
  logic              Mem_Write_E = 1'b0;
  logic              Result_src_E = 1'b0;
  logic [XLEN-1:0]   ALU_result_E = '0;
  logic [XLEN-1:0]   Write_Data_E = '0;
  logic [REG_AW-1:0] RDadd_E = '0;
  logic              valid_M;
  logic              ready_M = 1'b0;
  logic              RegW_enable_M, Mem_Write_M, Result_src_M;
  logic [XLEN-1:0]   ALU_result_M, Write_Data_M;
  logic [REG_AW-1:0] RDadd_M;

  int n_cmp = 0;
  int n_bad = 0;

  bun_t q[$];
  bun_t last_shown = '0;
  bun_t w_act, w_in;

  assign w_act = {RegW_enable_M, Mem_Write_M, Result_src_M, ALU_result_M, Write_Data_M, RDadd_M};
  assign w_in  = {RegW_enable_E, Mem_Write_E, Result_src_E, ALU_result_E, Write_Data_E, RDadd_E};

  ex_mem_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .valid_E(valid_E), .ready_E(ready_E),
    .RegW_enable_E(RegW_enable_E), .Mem_Write_E(Mem_Write_E), .Result_src_E(Result_src_E),
    .ALU_result_E(ALU_result_E), .Write_Data_E(Write_Data_E), .RDadd_E(RDadd_E),
    .valid_M(valid_M), .ready_M(ready_M),
    .RegW_enable_M(RegW_enable_M), .Mem_Write_M(Mem_Write_M), .Result_src_M(Result_src_M),
    .ALU_result_M(ALU_result_M), .Write_Data_M(Write_Data_M), .RDadd_M(RDadd_M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor / scoreboard: checks outputs mid-cycle, then applies the
  // transfers that the coming rising edge will perform.
  always @(negedge clk) begin
    bun_t exp_b;
    logic exp_ready, out_acc, in_acc;
    if (rst) begin
      q.delete();
      last_shown = '0;
      chk("rst_valid_M", {71'd0, valid_M}, 72'd0);
      chk("rst_ready_E", {71'd0, ready_E}, 72'd1);
      chk("rst_payload", w_act, 72'd0);
    end else begin
      exp_ready = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || ready_M);
      chk("ready_E", {71'd0, ready_E}, {71'd0, exp_ready});
      chk("valid_M", {71'd0, valid_M}, {71'd0, q.size() != 0});
      if (q.size() != 0) begin
        exp_b = q[0];
        last_shown = q[0];
        chk("bundle", w_act, exp_b);
      end else begin
        exp_b = last_shown;
        exp_b.regw = 1'b0;
        exp_b.memw = 1'b0;
        chk("bubble", w_act, exp_b);
      end
      out_acc = (q.size() != 0) && ready_M;
      in_acc  = valid_E && exp_ready;
      if (out_acc) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_acc) q.push_back(w_in);
    end
  end

  // Drive one cycle of stimulus just after the rising edge.
  task automatic step(input logic v, input logic [XLEN-1:0] alu, input logic rm, input logic fl,
                      input logic rw = 1'b0, input logic mw = 1'b0, input logic [REG_AW-1:0] rd = 5'd0);
    @(posedge clk);
    #1;
    valid_E       = v;
    ALU_result_E  = alu;
    Write_Data_E  = $urandom;
    Result_src_E  = 1'($urandom_range(1, 0));
    RegW_enable_E = rw;
    Mem_Write_E   = mw;
    RDadd_E       = rd;
    ready_M       = rm;
    flush         = fl;
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Stream 0x10..0x40 with downstream always ready
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i * 16), 1'b1, 1'b0, 1'b1, 1'b0, 5'(i));
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Backpressure, then drain
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with stage full and an input offered
    step(1'b1, 32'h1, 1'b0, 1'b0);
    step(1'b1, 32'h2, 1'b0, 1'b0);
    step(1'b1, 32'hD, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush together with a completing drain
    step(1'b1, 32'h55, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Bubble gating of write enables
    step(1'b1, 32'h77, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(1, 0)), $urandom, 1'($urandom_range(3, 0) != 0),
           1'($urandom_range(19, 0) == 0), 1'($urandom_range(1, 0)),
           1'($urandom_range(1, 0)), 5'($urandom));

    // Asynchronous reset while stalled with the stage full
    step(1'b1, 32'hE1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3);
    step(1'b1, 32'hE2, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("async_rst_valid_M", {71'd0, valid_M}, 72'd0);
    chk("async_rst_ready_E", {71'd0, ready_E}, 72'd1);
    chk("async_rst_payload", w_act, 72'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 32'hF0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
